// File: rtl/q_update_writer.sv
// Q-learning update writer: read-modify-write of one Q-table entry per request.
// Optional clamping of the updated value enabled by defining Q_UPD_SAT_EN.
module q_update_writer #(
  parameter int STATE_W     = 8,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [STATE_W-1:0] upd_state,
  input  logic [3:0]         upd_action,
  input  logic [15:0]        upd_reward,
  input  logic [15:0]        upd_max_next,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [STATE_W+3:0] mem_addr,
  output logic [15:0]        mem_wr_data,
  input  logic [15:0]        mem_rd_data,
  output logic               upd_done,
  output logic               upd_err,
  output logic [15:0]        upd_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_CALC,
    S_WR,
    S_ERR
  } st_t;

  st_t         st;
  logic [15:0] rew_r;
  logic [15:0] max_r;
  logic [15:0] q_r;

  logic signed [18:0] m_x;
  logic signed [18:0] g;
  logic signed [18:0] t;
  logic signed [18:0] d;
  logic signed [18:0] n;
  logic [15:0]        wr_val;

  always_comb begin
    m_x = {3'b000, max_r};
    g   = m_x - (m_x >> GAMMA_SHIFT);
    t   = {{3{rew_r[15]}}, rew_r} + g;
    d   = t - {3'b000, q_r};
    n   = {3'b000, q_r} + (d >>> ALPHA_SHIFT);
`ifdef Q_UPD_SAT_EN
    if (n[18])
      wr_val = 16'h0000;
    else if (|n[17:16])
      wr_val = 16'hFFFF;
    else
      wr_val = n[15:0];
`else
    wr_val = n[15:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      upd_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      upd_done    <= 1'b0;
      upd_err     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      upd_cnt     <= '0;
      rew_r       <= '0;
      max_r       <= '0;
      q_r         <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      upd_done  <= 1'b0;
      upd_err   <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (upd_valid && upd_ready) begin
            upd_ready <= 1'b0;
            if (upd_action > 4'd8) begin
              st      <= S_ERR;
              upd_err <= 1'b1;
            end else begin
              st        <= S_RD;
              mem_rd_en <= 1'b1;
              mem_addr  <= {upd_state, upd_action};
              rew_r     <= upd_reward;
              max_r     <= upd_max_next;
            end
          end
        end
        S_RD: st <= S_WT;
        S_WT: begin
          q_r <= mem_rd_data;
          st  <= S_CALC;
        end
        S_CALC: begin
          mem_wr_data <= wr_val;
          mem_wr_en   <= 1'b1;
          upd_done    <= 1'b1;
          upd_cnt     <= upd_cnt + 16'd1;
          st          <= S_WR;
        end
        S_WR, S_ERR: begin
          st        <= S_IDLE;
          upd_ready <= 1'b1;
        end
        default: begin
          st        <= S_IDLE;
          upd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_update_writer.sv
// Scoreboard bench for q_update_writer (ALPHA_SHIFT=2, GAMMA_SHIFT=3).
// Writes are checked by a monitor against a queue filled by the driver.
module tb_q_update_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  upd_state = '0;
  logic [3:0]  upd_action = '0;
  logic [15:0] upd_reward = '0;
  logic [15:0] upd_max_next = '0;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data = '0;
  logic        upd_done;
  logic        upd_err;
  logic [15:0] upd_cnt;

  q_update_writer #(
    .STATE_W(8),
    .ALPHA_SHIFT(2),
    .GAMMA_SHIFT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_state(upd_state),
    .upd_action(upd_action),
    .upd_reward(upd_reward),
    .upd_max_next(upd_max_next),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .upd_done(upd_done),
    .upd_err(upd_err),
    .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        wq[$];
  int          eq[$];
  logic [15:0] mem [0:4095];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_m = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write and every error pulse is matched to the queues.
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h want none",
                 mem_addr);
      end else begin
        exp_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wr_data), 32'(e.data));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_done", 32'(upd_done), 32'd1);
        chk("wr_cnt", 32'(upd_cnt), 32'(e.cnt));
      end
    end else if (upd_done) begin
      chk("done_no_wr", 32'(upd_done), 32'd0);
    end
    if (upd_err) begin
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_err: got 1 want 0");
      end else begin
        chk("err_cycle", 32'(cyc), 32'(eq.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] s, input logic [3:0] a,
                      input logic [15:0] r, input logic [15:0] m,
                      input logic [15:0] expd, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 want 1");
      return;
    end
    upd_valid    = 1'b1;
    upd_state    = s;
    upd_action   = a;
    upd_reward   = r;
    upd_max_next = m;
    if (push) begin
      if (a <= 4'd8) begin
        cnt_m  = cnt_m + 16'd1;
        e.addr = {s, a};
        e.data = expd;
        e.cyc  = cyc + 4;
        e.cnt  = cnt_m;
        wq.push_back(e);
      end else begin
        eq.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  localparam logic [15:0] EXP_NEG =
`ifdef Q_UPD_SAT_EN
    16'h0000;
`else
    16'hFFD5;
`endif
  localparam logic [15:0] EXP_BIG =
`ifdef Q_UPD_SAT_EN
    16'hFFFF;
`else
    16'h17FF;
`endif

  initial begin
    int rd0;
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[{8'h01, 4'd0}] = 16'd100;
    mem[{8'h02, 4'd3}] = 16'd100;
    mem[{8'h03, 4'd8}] = 16'd10;
    mem[{8'h04, 4'd4}] = 16'd65535;
    mem[{8'h05, 4'd1}] = 16'd0;
    mem[{8'h06, 4'd7}] = 16'd1000;
    mem[{8'h30, 4'd1}] = 16'd500;
    mem[{8'h31, 4'd2}] = 16'd100;

    #12;
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_done", 32'(upd_done), 32'd0);
    chk("rst_err", 32'(upd_err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wr_data), 32'd0);
    chk("rst_cnt", 32'(upd_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector: also probe the ready window around it.
    k = cyc;
    send(8'h01, 4'd0, 16'd40, 16'd80, 16'd102, 1);
    @(negedge clk);
    chk("rd_strobe", 32'(mem_rd_en), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h010);
    chk("busy_ready", 32'(upd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("wr_ready_low", 32'(upd_ready), 32'd0);
    @(negedge clk);
    chk("ready_back", 32'(upd_ready), 32'd1);

    send(8'h02, 4'd3, 16'hFFC4, 16'd0, 16'd60, 1);
    send(8'h03, 4'd8, 16'hFF38, 16'd0, EXP_NEG, 1);
    send(8'h04, 4'd4, 16'h7FFF, 16'hFFFF, EXP_BIG, 1);
    send(8'h05, 4'd1, 16'd0, 16'd0, 16'd0, 1);
    send(8'h06, 4'd7, 16'd16, 16'd1000, 16'd972, 1);

    // Illegal action.
    repeat (6) @(negedge clk);
    rd0 = rd_cnt;
    send(8'h07, 4'd9, 16'd5, 16'd5, 16'd0, 1);
    @(negedge clk);
    chk("err_ready_low", 32'(upd_ready), 32'd0);
    chk("err_cnt", 32'(upd_cnt), 32'(cnt_m));
    @(negedge clk);
    chk("err_ready_back", 32'(upd_ready), 32'd1);
    chk("err_no_rd", 32'(rd_cnt), 32'(rd0));

    // Reset during WT with a request held during reset.
    send(8'h30, 4'd1, 16'd1000, 16'd1000, 16'd0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b1;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
    chk("abort_ready", 32'(upd_ready), 32'd1);
    chk("abort_cnt", 32'(upd_cnt), 32'd0);
    rd0 = rd_cnt;
    repeat (2) @(negedge clk);
    chk("rst_no_accept", 32'(rd_cnt), 32'(rd0));
    upd_valid = 1'b0;
    rst_n = 1'b1;
    cnt_m = '0;
    repeat (6) @(negedge clk);
    chk("abort_mem", 32'(mem[{8'h30, 4'd1}]), 32'd500);
    send(8'h31, 4'd2, 16'd40, 16'd80, 16'd102, 1);

    k = 0;
    while ((wq.size() != 0 || eq.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("eq_drained", 32'(eq.size()), 32'd0);
    chk("final_cnt", 32'(upd_cnt), 32'd1);
    chk("final_mem", 32'(mem[{8'h31, 4'd2}]), 32'd102);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
